trig_window_readout: RTL



---
 rtl/trig_window_readout.sv | 118 +++++++++++
 1 files changed

// File: rtl/trig_window_readout.sv
// Circular sample recorder that streams out a pre/post-trigger window on demand.
// The write side never stalls; reads trail writes by at least pre_len+1 addresses.
module trig_window_readout #(
  parameter int BITS      = 16,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITS-1:0]      d_in,
  input  logic                 trig,
  input  logic [ADDR_BITS-1:0] pre_len,
  input  logic [ADDR_BITS-1:0] post_len,
  output logic [BITS-1:0]      d_out,
  output logic                 out_valid,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 busy,
  output logic                 trig_accepted,
  output logic [15:0]          dropped_count
);
  localparam int AW1 = ADDR_BITS + 1;

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] READ  = 2'd2;

  logic [BITS-1:0]      mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr, fill_cnt;
  logic [AW1-1:0]       len_q, rd_left, win_len;
  logic [1:0]           state;
  logic                 fill_ok, accept, rd_active;
  logic                 s1_valid, s1_first, s1_last;
  logic [BITS-1:0]      s1_data;

  assign fill_ok   = fill_cnt >= pre_len;
  assign accept    = (state == ARMED) && fill_ok && trig;
  assign busy      = (state == READ);
  assign rd_active = busy && (rd_left != '0);
  assign win_len   = AW1'(pre_len) + AW1'(post_len) + AW1'(1);

  // Buffer is never cleared; the read register sits beside it so it maps to block RAM.
  always_ff @(posedge clk) begin
    mem[wr_ptr] <= d_in;
    s1_data     <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_BITS'(1);
      if (fill_cnt != '1) fill_cnt <= fill_cnt + ADDR_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FILL;
      rd_ptr        <= '0;
      len_q         <= '0;
      rd_left       <= '0;
      trig_accepted <= 1'b0;
    end else begin
      trig_accepted <= accept;
      case (state)
        FILL:  if (fill_ok) state <= ARMED;
        ARMED: begin
          if (!fill_ok) begin
            state <= FILL;
          end else if (trig) begin
            state   <= READ;
            rd_ptr  <= wr_ptr - pre_len;
            len_q   <= win_len;
            rd_left <= win_len;
          end
        end
        READ: begin
          if (rd_active) begin
            rd_ptr  <= rd_ptr + ADDR_BITS'(1);
            rd_left <= rd_left - AW1'(1);
          end
          // busy spans the out_last cycle, so leave READ on the edge that ends it
          if (out_last) state <= ARMED;
        end
        default: state <= FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      d_out     <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      s1_valid  <= rd_active;
      s1_first  <= rd_active && (rd_left == len_q);
      s1_last   <= rd_active && (rd_left == AW1'(1));
      d_out     <= s1_valid ? s1_data : '0;
      out_valid <= s1_valid;
      out_first <= s1_first;
      out_last  <= s1_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropped_count <= '0;
    end else if (trig && busy && dropped_count != 16'hFFFF) begin
      dropped_count <= dropped_count + 16'd1;
    end
  end
endmodule
